// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate-generation pipeline stage.
// Format encodings and skid-buffer states.
package imm_gen_pkg;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_ILL   = 3'b110,
        IMM_BU    = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder.
// instr holds instruction bits [31:7], so instr[k-7] is bit k.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = XLEN_32
) (
    input  logic [24:0]     instr,
    input  imm_src_e        src,
    input  logic            sgn,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    localparam int SH_W = (XLEN == XLEN_64) ? 6 : 5;

    logic s;
    assign s = instr[24];

    // Fill with the extension bit first, then overlay the low field.
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        unique case (src)
            IMM_I: begin
                imm        = {XLEN{s & sgn}};
                imm[11:0]  = instr[24:13];
            end
            IMM_S: begin
                imm        = {XLEN{s}};
                imm[11:0]  = {instr[24:18], instr[4:0]};
            end
            IMM_B: begin
                imm        = {XLEN{s}};
                imm[12:0]  = {s, instr[0], instr[23:18], instr[4:1], 1'b0};
            end
            IMM_U: begin
                imm        = {XLEN{s}};
                imm[31:0]  = {instr[24:5], 12'b0};
            end
            IMM_J: begin
                imm        = {XLEN{s}};
                imm[20:0]  = {s, instr[12:5], instr[13], instr[23:14], 1'b0};
            end
            IMM_SHAMT: begin
                imm[SH_W-1:0] = instr[12+SH_W:13];
            end
            IMM_ILL: begin
                illegal = 1'b1;
            end
            IMM_BU: begin
                imm[12:0]  = {s, instr[0], instr[23:18], instr[4:1], 1'b0};
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator behind a 2-entry in-order skid buffer.
// Slot 0 always holds the oldest entry and drives the outputs.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = XLEN_32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [24:0]      instr_31_7_i,
    input  logic [2:0]       imm_src_i,
    input  logic             signed_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  imm_ext_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             illegal_o
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (instr_31_7_i),
        .src     (imm_src_e'(imm_src_i)),
        .sgn     (signed_i),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    buf_state_e       state, state_nx;
    logic             ready_q;
    logic [XLEN-1:0]  imm0, imm1;
    logic [TAG_W-1:0] tag0, tag1;
    logic             ill0, ill1;
    logic             acc, xfer;
    logic             load0, load1, shift;

    assign acc  = valid_i && ready_q;
    assign xfer = valid_o && ready_i;

    always_comb begin
        state_nx = state;
        load0    = 1'b0;
        load1    = 1'b0;
        shift    = 1'b0;
        if (flush_i) begin
            state_nx = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        state_nx = ST_ONE;
                        load0    = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (acc && !xfer) begin
                        state_nx = ST_FULL;
                        load1    = 1'b1;
                    end else if (acc && xfer) begin
                        load0    = 1'b1;
                    end else if (xfer) begin
                        state_nx = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer) begin
                        state_nx = ST_ONE;
                        shift    = 1'b1;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    // ready is a flop so it never sees ready_i combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
            imm0    <= '0;
            imm1    <= '0;
            tag0    <= '0;
            tag1    <= '0;
            ill0    <= 1'b0;
            ill1    <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != ST_FULL);
            if (load0) begin
                imm0 <= dec_imm;
                tag0 <= tag_i;
                ill0 <= dec_ill;
            end else if (shift) begin
                imm0 <= imm1;
                tag0 <= tag1;
                ill0 <= ill1;
            end
            if (load1) begin
                imm1 <= dec_imm;
                tag1 <= tag_i;
                ill1 <= dec_ill;
            end
        end
    end

    assign valid_o   = (state != ST_EMPTY);
    assign ready_o   = ready_q;
    assign imm_ext_o = valid_o ? imm0 : '0;
    assign tag_o     = valid_o ? tag0 : '0;
    assign illegal_o = valid_o && ill0;

endmodule
